// File: rtl/control_reloj_config.sv
// Time/date/countdown keeper with a pushbutton configuration FSM.
// Feeds registered BCD digits, weekday, edit mode and cursor to the clock frame generator.
`timescale 1ns / 1ps
module control_reloj_config #(
  parameter int unsigned TIMER_HH_MAX = 23
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       btn_config,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic [3:0] digit0_HH,
  output logic [3:0] digit1_HH,
  output logic [3:0] digit0_MM,
  output logic [3:0] digit1_MM,
  output logic [3:0] digit0_SS,
  output logic [3:0] digit1_SS,
  output logic [3:0] digit0_DAY,
  output logic [3:0] digit1_DAY,
  output logic [3:0] digit0_MES,
  output logic [3:0] digit1_MES,
  output logic [3:0] digit0_YEAR,
  output logic [3:0] digit1_YEAR,
  output logic [3:0] digit0_HH_T,
  output logic [3:0] digit1_HH_T,
  output logic [3:0] digit0_MM_T,
  output logic [3:0] digit1_MM_T,
  output logic [3:0] digit0_SS_T,
  output logic [3:0] digit1_SS_T,
  output logic       AM_PM,
  output logic [2:0] dia_semana,
  output logic       funcion,
  output logic [1:0] cursor_location,
  output logic [1:0] config_grupo,
  output logic       timer_fin
);

  localparam logic [1:0] StNormal = 2'b00;
  localparam logic [1:0] StHora   = 2'b01;
  localparam logic [1:0] StFecha  = 2'b10;
  localparam logic [1:0] StTimer  = 2'b11;

  localparam logic [1:0] CurHi  = 2'b10;
  localparam logic [1:0] CurMid = 2'b01;
  localparam logic [1:0] CurLo  = 2'b00;
  localparam logic [1:0] CurDow = 2'b11;

  localparam logic [6:0] TimerHhMax = 7'(TIMER_HH_MAX);

  function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic [6:0] y);
    logic [4:0] dim;
    case (m)
      4'd2:                    dim = (y[1:0] == 2'b00) ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11: dim = 5'd30;
      default:                 dim = 5'd31;
    endcase
    return dim;
  endfunction

  function automatic logic [7:0] to_bcd(input logic [6:0] b);
    logic [6:0] tens;
    logic [6:0] units;
    tens  = b / 7'd10;
    units = b - tens * 7'd10;
    return {tens[3:0], units[3:0]};
  endfunction

  function automatic logic [6:0] step_wrap(input logic [6:0] v, input logic [6:0] lo,
                                           input logic [6:0] hi, input logic up);
    if (up) return (v >= hi) ? lo : v + 7'd1;
    return (v <= lo) ? hi : v - 7'd1;
  endfunction

  logic [3:0] hh_q, hh_d;
  logic [5:0] mm_q, mm_d, ss_q, ss_d;
  logic       ampm_q, ampm_d;
  logic [4:0] day_q, day_d;
  logic [3:0] mes_q, mes_d;
  logic [6:0] year_q, year_d;
  logic [2:0] dow_q, dow_d;
  logic [6:0] hht_q, hht_d;
  logic [5:0] mmt_q, mmt_d, sst_q, sst_d;
  logic [1:0] state_q, state_d;
  logic [1:0] cursor_q, cursor_d;
  logic       fin_q, fin_d;

  logic       do_cfg, do_left, do_right, do_up, do_down, any_btn, edit;
  logic       day_carry, timer_nz;
  logic [4:0] dim_cur, dim_new;
  logic [3:0] mes_new;
  logic [6:0] year_new;

  assign dim_cur = days_in_month(mes_q, year_q);

  always_comb begin
    hh_d      = hh_q;
    mm_d      = mm_q;
    ss_d      = ss_q;
    ampm_d    = ampm_q;
    day_d     = day_q;
    mes_d     = mes_q;
    year_d    = year_q;
    dow_d     = dow_q;
    hht_d     = hht_q;
    mmt_d     = mmt_q;
    sst_d     = sst_q;
    state_d   = state_q;
    cursor_d  = cursor_q;
    fin_d     = fin_q;
    day_carry = 1'b0;
    mes_new   = mes_q;
    year_new  = year_q;
    dim_new   = dim_cur;

    // Fixed priority: exactly one button acts per cycle.
    do_cfg   = btn_config;
    do_left  = !btn_config && btn_left;
    do_right = !btn_config && !btn_left && btn_right;
    do_up    = !btn_config && !btn_left && !btn_right && btn_up;
    do_down  = !btn_config && !btn_left && !btn_right && !btn_up && btn_down;
    any_btn  = btn_config | btn_left | btn_right | btn_up | btn_down;
    edit     = (do_up || do_down) && (state_q != StNormal);
    timer_nz = (hht_q != 7'd0) || (mmt_q != 6'd0) || (sst_q != 6'd0);

    if (tick_1hz && (state_q != StHora)) begin
      if (ss_q == 6'd59) begin
        ss_d = 6'd0;
        if (mm_q == 6'd59) begin
          mm_d = 6'd0;
          if (hh_q == 4'd12) begin
            hh_d = 4'd1;
          end else begin
            hh_d = hh_q + 4'd1;
            if (hh_q == 4'd11) begin
              ampm_d    = !ampm_q;
              day_carry = ampm_q;
            end
          end
        end else begin
          mm_d = mm_q + 6'd1;
        end
      end else begin
        ss_d = ss_q + 6'd1;
      end
    end

    // While the date is being edited the carry is dropped; the edit owns those fields.
    if (day_carry && (state_q != StFecha)) begin
      dow_d = (dow_q == 3'd6) ? 3'd0 : dow_q + 3'd1;
      if (day_q >= dim_cur) begin
        day_d = 5'd1;
        if (mes_q == 4'd12) begin
          mes_d  = 4'd1;
          year_d = (year_q == 7'd99) ? 7'd0 : year_q + 7'd1;
        end else begin
          mes_d = mes_q + 4'd1;
        end
      end else begin
        day_d = day_q + 5'd1;
      end
    end

    if (any_btn) fin_d = 1'b0;
    if (tick_1hz && (state_q != StTimer) && timer_nz) begin
      if (sst_q != 6'd0) begin
        sst_d = sst_q - 6'd1;
      end else begin
        sst_d = 6'd59;
        if (mmt_q != 6'd0) begin
          mmt_d = mmt_q - 6'd1;
        end else begin
          mmt_d = 6'd59;
          hht_d = hht_q - 7'd1;
        end
      end
      if ((hht_q == 7'd0) && (mmt_q == 6'd0) && (sst_q == 6'd1)) fin_d = 1'b1;
    end

    if (do_cfg) begin
      state_d  = state_q + 2'd1;
      cursor_d = (state_q == StTimer) ? CurLo : CurHi;
    end else if (state_q != StNormal) begin
      if (do_right) begin
        unique case (cursor_q)
          CurHi:  cursor_d = CurMid;
          CurMid: cursor_d = CurLo;
          CurLo:  cursor_d = (state_q == StFecha) ? CurDow : CurHi;
          CurDow: cursor_d = CurHi;
        endcase
      end else if (do_left) begin
        unique case (cursor_q)
          CurHi:  cursor_d = (state_q == StFecha) ? CurDow : CurLo;
          CurMid: cursor_d = CurHi;
          CurLo:  cursor_d = CurMid;
          CurDow: cursor_d = CurLo;
        endcase
      end
    end

    if (edit) begin
      unique case (state_q)
        StNormal: ;
        StHora: begin
          unique case (cursor_q)
            CurHi: begin
              hh_d = 4'(step_wrap({3'b0, hh_q}, 7'd1, 7'd12, do_up));
              if ((do_up && hh_q == 4'd11) || (do_down && hh_q == 4'd12)) ampm_d = !ampm_q;
            end
            CurMid: mm_d = 6'(step_wrap({1'b0, mm_q}, 7'd0, 7'd59, do_up));
            CurLo:  ss_d = 6'(step_wrap({1'b0, ss_q}, 7'd0, 7'd59, do_up));
            CurDow: ;
          endcase
        end
        StFecha: begin
          unique case (cursor_q)
            CurHi: day_d = 5'(step_wrap({2'b0, day_q}, 7'd1, {2'b0, dim_cur}, do_up));
            CurMid: begin
              mes_new = 4'(step_wrap({3'b0, mes_q}, 7'd1, 7'd12, do_up));
              dim_new = days_in_month(mes_new, year_q);
              mes_d   = mes_new;
              day_d   = (day_q > dim_new) ? dim_new : day_q;
            end
            CurLo: begin
              year_new = step_wrap(year_q, 7'd0, 7'd99, do_up);
              dim_new  = days_in_month(mes_q, year_new);
              year_d   = year_new;
              day_d    = (day_q > dim_new) ? dim_new : day_q;
            end
            CurDow: dow_d = 3'(step_wrap({4'b0, dow_q}, 7'd0, 7'd6, do_up));
          endcase
        end
        StTimer: begin
          unique case (cursor_q)
            CurHi:  hht_d = step_wrap(hht_q, 7'd0, TimerHhMax, do_up);
            CurMid: mmt_d = 6'(step_wrap({1'b0, mmt_q}, 7'd0, 7'd59, do_up));
            CurLo:  sst_d = 6'(step_wrap({1'b0, sst_q}, 7'd0, 7'd59, do_up));
            CurDow: ;
          endcase
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hh_q     <= 4'd12;
      mm_q     <= 6'd0;
      ss_q     <= 6'd0;
      ampm_q   <= 1'b0;
      day_q    <= 5'd1;
      mes_q    <= 4'd1;
      year_q   <= 7'd0;
      dow_q    <= 3'd5;
      hht_q    <= 7'd0;
      mmt_q    <= 6'd0;
      sst_q    <= 6'd0;
      state_q  <= StNormal;
      cursor_q <= CurLo;
      fin_q    <= 1'b0;
      funcion  <= 1'b0;
      {digit1_HH, digit0_HH}     <= 8'h12;
      {digit1_MM, digit0_MM}     <= 8'h00;
      {digit1_SS, digit0_SS}     <= 8'h00;
      {digit1_DAY, digit0_DAY}   <= 8'h01;
      {digit1_MES, digit0_MES}   <= 8'h01;
      {digit1_YEAR, digit0_YEAR} <= 8'h00;
      {digit1_HH_T, digit0_HH_T} <= 8'h00;
      {digit1_MM_T, digit0_MM_T} <= 8'h00;
      {digit1_SS_T, digit0_SS_T} <= 8'h00;
    end else begin
      hh_q     <= hh_d;
      mm_q     <= mm_d;
      ss_q     <= ss_d;
      ampm_q   <= ampm_d;
      day_q    <= day_d;
      mes_q    <= mes_d;
      year_q   <= year_d;
      dow_q    <= dow_d;
      hht_q    <= hht_d;
      mmt_q    <= mmt_d;
      sst_q    <= sst_d;
      state_q  <= state_d;
      cursor_q <= cursor_d;
      fin_q    <= fin_d;
      funcion  <= (state_d != StNormal);
      {digit1_HH, digit0_HH}     <= to_bcd({3'b0, hh_d});
      {digit1_MM, digit0_MM}     <= to_bcd({1'b0, mm_d});
      {digit1_SS, digit0_SS}     <= to_bcd({1'b0, ss_d});
      {digit1_DAY, digit0_DAY}   <= to_bcd({2'b0, day_d});
      {digit1_MES, digit0_MES}   <= to_bcd({3'b0, mes_d});
      {digit1_YEAR, digit0_YEAR} <= to_bcd(year_d);
      {digit1_HH_T, digit0_HH_T} <= to_bcd(hht_d);
      {digit1_MM_T, digit0_MM_T} <= to_bcd({1'b0, mmt_d});
      {digit1_SS_T, digit0_SS_T} <= to_bcd({1'b0, sst_d});
    end
  end

  assign AM_PM           = ampm_q;
  assign dia_semana      = dow_q;
  assign cursor_location = cursor_q;
  assign config_grupo    = state_q;
  assign timer_fin       = fin_q;

endmodule

// File: tb/tb_control_reloj_config.sv
// Scoreboard bench for control_reloj_config: each driven cycle pushes the expected
// output snapshot, which is popped and compared one edge later.
`timescale 1ns / 1ps
module tb_control_reloj_config;
  logic clk = 1'b0;
  logic reset;
  logic tick_1hz, btn_config, btn_up, btn_down, btn_left, btn_right;
  logic [3:0] digit0_HH, digit1_HH, digit0_MM, digit1_MM, digit0_SS, digit1_SS;
  logic [3:0] digit0_DAY, digit1_DAY, digit0_MES, digit1_MES, digit0_YEAR, digit1_YEAR;
  logic [3:0] digit0_HH_T, digit1_HH_T, digit0_MM_T, digit1_MM_T, digit0_SS_T, digit1_SS_T;
  logic       AM_PM, funcion, timer_fin;
  logic [2:0] dia_semana;
  logic [1:0] cursor_location, config_grupo;

  always #5 clk = ~clk;

  control_reloj_config #(.TIMER_HH_MAX(23)) dut (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz),
    .btn_config(btn_config), .btn_up(btn_up), .btn_down(btn_down),
    .btn_left(btn_left), .btn_right(btn_right),
    .digit0_HH(digit0_HH), .digit1_HH(digit1_HH), .digit0_MM(digit0_MM),
    .digit1_MM(digit1_MM), .digit0_SS(digit0_SS), .digit1_SS(digit1_SS),
    .digit0_DAY(digit0_DAY), .digit1_DAY(digit1_DAY), .digit0_MES(digit0_MES),
    .digit1_MES(digit1_MES), .digit0_YEAR(digit0_YEAR), .digit1_YEAR(digit1_YEAR),
    .digit0_HH_T(digit0_HH_T), .digit1_HH_T(digit1_HH_T), .digit0_MM_T(digit0_MM_T),
    .digit1_MM_T(digit1_MM_T), .digit0_SS_T(digit0_SS_T), .digit1_SS_T(digit1_SS_T),
    .AM_PM(AM_PM), .dia_semana(dia_semana), .funcion(funcion),
    .cursor_location(cursor_location), .config_grupo(config_grupo), .timer_fin(timer_fin)
  );

  logic [81:0] dut_snap;
  assign dut_snap = {digit1_HH, digit0_HH, digit1_MM, digit0_MM, digit1_SS, digit0_SS,
                     digit1_DAY, digit0_DAY, digit1_MES, digit0_MES, digit1_YEAR, digit0_YEAR,
                     digit1_HH_T, digit0_HH_T, digit1_MM_T, digit0_MM_T, digit1_SS_T, digit0_SS_T,
                     AM_PM, dia_semana, funcion, cursor_location, config_grupo, timer_fin};

  int vectors = 0;
  int miscompares = 0;
  int e_hh, e_mm, e_ss, e_ampm, e_day, e_mes, e_yr, e_dow;
  int e_hht, e_mmt, e_sst, e_fun, e_cur, e_grp, e_fin;

  logic [81:0] exp_q[$];
  string       tag_q[$];
  logic [81:0] cmp_exp;
  string       cmp_tag;

  function automatic logic [7:0] bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  function automatic logic [81:0] exp_snap();
    return {bcd(e_hh), bcd(e_mm), bcd(e_ss), bcd(e_day), bcd(e_mes), bcd(e_yr),
            bcd(e_hht), bcd(e_mmt), bcd(e_sst), 1'(e_ampm), 3'(e_dow), 1'(e_fun),
            2'(e_cur), 2'(e_grp), 1'(e_fin)};
  endfunction

  task automatic expect_reset_values();
    e_hh = 12; e_mm = 0; e_ss = 0; e_ampm = 0;
    e_day = 1; e_mes = 1; e_yr = 0; e_dow = 5;
    e_hht = 0; e_mmt = 0; e_sst = 0;
    e_fun = 0; e_cur = 0; e_grp = 0; e_fin = 0;
  endtask

  // Scoreboard consumer: outputs settle one cycle after the driven pulse.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      cmp_exp = exp_q.pop_front();
      cmp_tag = tag_q.pop_front();
      vectors++;
      if (dut_snap !== cmp_exp) begin
        miscompares++;
        $display("FAIL %s: got %h expected %h", cmp_tag, dut_snap, cmp_exp);
      end
    end
  end

  task automatic step(input logic c, input logic l, input logic r, input logic u,
                      input logic d, input logic t, input string tag);
    @(negedge clk);
    btn_config = c; btn_left = l; btn_right = r; btn_up = u; btn_down = d; tick_1hz = t;
    exp_q.push_back(exp_snap());
    tag_q.push_back(tag);
    @(posedge clk);
    #2;
    btn_config = 0; btn_left = 0; btn_right = 0; btn_up = 0; btn_down = 0; tick_1hz = 0;
  endtask

  task automatic cfg(input string tag);   step(1, 0, 0, 0, 0, 0, tag); endtask
  task automatic left(input string tag);  step(0, 1, 0, 0, 0, 0, tag); endtask
  task automatic right(input string tag); step(0, 0, 1, 0, 0, 0, tag); endtask
  task automatic up(input string tag);    step(0, 0, 0, 1, 0, 0, tag); endtask
  task automatic down(input string tag);  step(0, 0, 0, 0, 1, 0, tag); endtask
  task automatic tick(input string tag);  step(0, 0, 0, 0, 0, 1, tag); endtask

  // From NORMAL at 12 AM: set 11:59:59 PM, leave the FSM in CFG_FECHA on DAY.
  task automatic set_eve();
    e_grp = 1; e_fun = 1; e_cur = 2; cfg("enter_hora");
    e_hh = 11; e_ampm = 1; down("hh_12am_down_11pm");
    e_cur = 1; right("cur_to_mm");
    while (e_mm != 59) begin
      e_mm = (e_mm == 0) ? 59 : e_mm - 1;
      down("mm_down");
    end
    e_cur = 0; right("cur_to_ss");
    while (e_ss != 59) begin
      e_ss = (e_ss == 0) ? 59 : e_ss - 1;
      down("ss_down");
    end
    e_grp = 2; e_cur = 2; cfg("enter_fecha");
  endtask

  task automatic leave_fecha();
    e_grp = 3; e_cur = 2; cfg("enter_timer");
    e_grp = 0; e_fun = 0; e_cur = 0; cfg("back_to_normal");
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (dut_snap !== exp_snap()) begin
      miscompares++;
      $display("FAIL reset_values: got %h expected %h", dut_snap, exp_snap());
    end
    @(negedge clk);
    reset = 0;
    e_ss = 1; tick("first_tick");
  endtask

  task automatic test_rollover();
    set_eve();
    e_day = 31; down("day_wrap_to_31");
    repeat (3) begin e_day--; down("day_down"); end
    e_cur = 1; right("cur_to_mes");
    e_mes = 2; up("mes_to_feb");
    e_cur = 0; right("cur_to_year");
    repeat (4) begin e_yr++; up("year_up"); end
    leave_fecha();
    e_hh = 12; e_mm = 0; e_ss = 0; e_ampm = 0; e_day = 29; e_dow = 6;
    tick("leap_feb28_rollover");
    set_eve();
    leave_fecha();
    e_hh = 12; e_mm = 0; e_ss = 0; e_ampm = 0; e_day = 1; e_mes = 3; e_dow = 0;
    tick("leap_feb29_rollover");
    set_eve();
    e_day = 31; down("day_wrap_mar");
    repeat (3) begin e_day--; down("day_down"); end
    e_cur = 1; right("cur_to_mes");
    e_mes = 2; down("mes_down_to_feb");
    e_cur = 0; right("cur_to_year");
    e_yr = 5; up("year_to_05");
    leave_fecha();
    e_hh = 12; e_mm = 0; e_ss = 0; e_ampm = 0; e_day = 1; e_mes = 3; e_dow = 1;
    tick("nonleap_feb28_rollover");
  endtask

  task automatic test_hora();
    e_grp = 1; e_fun = 1; e_cur = 2; cfg("enter_hora");
    repeat (13) begin
      if (e_hh == 1) e_hh = 12;
      else begin
        if (e_hh == 12) e_ampm = 1 - e_ampm;
        e_hh--;
      end
      down("hh_walk_down");
    end
    e_hh = 12; e_ampm = 1; up("hh_11am_up_to_12pm");
    repeat (5) tick("tick_held_in_hora");
    e_cur = 1; right("right_1");
    e_cur = 0; right("right_2");
    e_cur = 2; right("right_wrap");
    e_cur = 0; left("left_wrap");
    e_ss = 59; down("ss_down_wrap");
    e_ss = 0; up("ss_up_wrap");
    e_grp = 2; e_cur = 2; cfg("enter_fecha");
  endtask

  task automatic test_fecha();
    e_cur = 1; right("cur_to_mes");
    e_cur = 0; right("cur_to_year");
    repeat (5) begin e_yr--; down("year_down"); end
    e_cur = 1; left("cur_back_mes");
    e_mes = 2; down("mes_down");
    e_mes = 1; down("mes_down_jan");
    e_cur = 2; left("cur_back_day");
    e_day = 31; down("day_wrap_jan");
    e_ss = 1; tick("tick_runs_in_fecha");
    e_cur = 1; right("cur_to_mes");
    e_mes = 2; e_day = 29; up("mes_clamps_day");
    e_cur = 0; right("cur_to_year");
    e_cur = 3; right("cur_to_dow");
    e_cur = 2; right("cur_dow_wrap");
    e_cur = 3; left("left_to_dow");
    e_dow = 0; down("dow_down");
    e_dow = 6; down("dow_wrap_low");
    e_dow = 0; up("dow_6_to_0");
    e_grp = 3; e_cur = 2; cfg("enter_timer");
  endtask

  task automatic test_timer();
    int rem;
    e_cur = 1; right("cur_to_mm_t");
    e_mmt = 1; up("mm_t_up");
    e_grp = 0; e_fun = 0; e_cur = 0; cfg("exit_to_normal");
    for (int i = 1; i <= 60; i++) begin
      e_ss++;
      if (e_ss == 60) begin e_ss = 0; e_mm++; end
      rem = 60 - i;
      e_mmt = rem / 60; e_sst = rem % 60;
      if (rem == 0) e_fin = 1;
      tick("timer_countdown");
    end
    e_ss++; tick("timer_stays_zero");
    e_fin = 0; up("button_clears_fin");
  endtask

  task automatic test_back_to_back();
    e_grp = 1; e_fun = 1; e_cur = 2; step(1, 0, 0, 1, 0, 0, "cfg_beats_up");
    e_hh = 1; step(0, 0, 0, 1, 1, 0, "up_beats_down");
    e_cur = 0; step(0, 1, 1, 0, 0, 0, "left_beats_right");
    e_grp = 2; e_cur = 2; cfg("enter_fecha");
    e_grp = 3; cfg("enter_timer");
    e_hht = 23; down("hh_t_wrap_low");
    e_hht = 0; up("hh_t_wrap_high");
    e_hht = 1; up("hh_t_up");
    e_ss++; tick("timer_held_in_cfg");
    @(negedge clk);
    #2;
    reset = 1;
    #1;
    expect_reset_values();
    vectors++;
    if (dut_snap !== exp_snap()) begin
      miscompares++;
      $display("FAIL async_reset: got %h expected %h", dut_snap, exp_snap());
    end
    @(negedge clk);
    reset = 0;
    e_ss = 1; tick("tick_after_reset");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach summary within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1;
    tick_1hz = 0; btn_config = 0; btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
    expect_reset_values();
    test_reset();
    test_rollover();
    test_hora();
    test_fecha();
    test_timer();
    test_back_to_back();
    @(posedge clk);
    #3;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
